// File: rtl/fsm_mon_pkg.sv
// Shared types and helpers for the FSM state monitor.
package fsm_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } mon_state_e;

    // Flat bit position of the prev->next entry in the transition mask.
    function automatic int unsigned trans_idx(input int unsigned prev,
                                              input int unsigned next,
                                              input int unsigned n);
        return prev * n + next;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that holds at MAX instead of wrapping.
module sat_counter #(
    parameter int unsigned    W   = 8,
    parameter logic [W-1:0]   MAX = '1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count_o,
    output logic         max_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != MAX)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count_o = count_q;
    assign max_o   = (count_q == MAX);

endmodule

// File: rtl/fsm_state_monitor.sv
// Runtime checker for a small FSM: tracks visited states, illegal encodings,
// disallowed transitions and stuck conditions from the sampled state bus.
module fsm_state_monitor
    import fsm_mon_pkg::*;
#(
    parameter int unsigned                        SW          = 2,
    parameter int unsigned                        NUM_STATES  = 3,
    parameter logic [NUM_STATES*NUM_STATES-1:0]   ALLOWED     = '1,
    parameter int unsigned                        STUCK_LIMIT = 8,
    parameter int unsigned                        CW          = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  state_valid,
    input  logic [SW-1:0]         state_in,
    output logic [NUM_STATES-1:0] visited,
    output logic                  all_visited,
    output logic                  illegal_state,
    output logic                  bad_transition,
    output logic                  stuck,
    output logic [CW-1:0]         trans_count,
    output logic [1:0]            mon_state
);

    localparam int unsigned STW    = $clog2(STUCK_LIMIT + 1);
    localparam int unsigned IW     = (NUM_STATES > 1) ? $clog2(NUM_STATES * NUM_STATES) : 1;
    localparam logic [SW:0] NS_LIM = (SW + 1)'(NUM_STATES);

    if (NUM_STATES > (2 ** SW)) begin : g_param_chk
        $error("fsm_state_monitor: NUM_STATES does not fit in SW bits");
    end

    mon_state_e            state_q, state_d;
    logic [SW-1:0]         prev_q;
    logic [NUM_STATES-1:0] visited_q, visited_d;
    logic                  all_visited_q, illegal_q, bad_q;

    logic                  sclr, legal, same;
    logic [IW-1:0]         idx;
    logic                  ev_vis, ev_ill, ev_bad, ev_stay_clr, ev_stay_inc, ev_trans;
    logic [STW-1:0]        stay_cnt;
    logic                  stay_max, trans_max;

    assign sclr  = rst | clear;
    assign legal = ({1'b0, state_in} < NS_LIM);
    assign same  = (state_in == prev_q);
    assign idx   = IW'(trans_idx(32'(prev_q), 32'(state_in), NUM_STATES));

    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (state_valid) state_d = legal ? TRACK : FAULT;
            TRACK:   if (state_valid && !legal) state_d = FAULT;
            default: state_d = state_q;
        endcase
    end

    // FAULT decodes to no events, which freezes every tracked quantity.
    always_comb begin
        ev_vis      = 1'b0;
        ev_ill      = 1'b0;
        ev_bad      = 1'b0;
        ev_stay_clr = 1'b0;
        ev_stay_inc = 1'b0;
        ev_trans    = 1'b0;
        if (state_valid) begin
            case (state_q)
                IDLE: begin
                    if (legal) begin
                        ev_vis      = 1'b1;
                        ev_stay_clr = 1'b1;
                    end else begin
                        ev_ill = 1'b1;
                    end
                end
                TRACK: begin
                    if (!legal) begin
                        ev_ill = 1'b1;
                    end else if (same) begin
                        ev_stay_inc = 1'b1;
                    end else begin
                        ev_trans    = 1'b1;
                        ev_vis      = 1'b1;
                        ev_stay_clr = 1'b1;
                        ev_bad      = ~ALLOWED[idx];
                    end
                end
                default: ;
            endcase
        end
    end

    assign visited_d = visited_q | (ev_vis ? (NUM_STATES'(1) << state_in) : '0);

    always_ff @(posedge clk) begin
        if (sclr) begin
            prev_q        <= '0;
            visited_q     <= '0;
            all_visited_q <= 1'b0;
            illegal_q     <= 1'b0;
            bad_q         <= 1'b0;
        end else begin
            if (ev_vis) prev_q <= state_in;
            visited_q     <= visited_d;
            all_visited_q <= &visited_d;
            if (ev_ill) illegal_q <= 1'b1;
            if (ev_bad) bad_q     <= 1'b1;
        end
    end

    sat_counter #(.W(CW)) u_trans_cnt (
        .clk     (clk),
        .clr     (sclr),
        .inc     (ev_trans & ~trans_max),
        .count_o (trans_count),
        .max_o   (trans_max)
    );

    sat_counter #(.W(STW), .MAX(STW'(STUCK_LIMIT))) u_stay_cnt (
        .clk     (clk),
        .clr     (sclr | ev_stay_clr),
        .inc     (ev_stay_inc & ~stay_max),
        .count_o (stay_cnt),
        .max_o   (stay_max)
    );

    assign visited        = visited_q;
    assign all_visited    = all_visited_q;
    assign illegal_state  = illegal_q;
    assign bad_transition = bad_q;
    assign stuck          = (stay_cnt == STW'(STUCK_LIMIT));
    assign mon_state      = state_q;

endmodule

// File: tb/tb_fsm_state_monitor.sv
// Directed scoreboard bench: the driver queues hand-computed expectations,
// a monitor pops one per clock edge and compares against the DUT outputs.
module tb_fsm_state_monitor;

    typedef struct packed {
        logic [2:0] vis;
        logic       av;
        logic       ill;
        logic       bad;
        logic       stk;
        logic [3:0] tc;
        logic [1:0] ms;
    } exp_t;

    typedef struct {
        string name;
        exp_t  e;
    } item_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       state_valid = 1'b0;
    logic [1:0] state_in = 2'd0;
    logic [2:0] visited;
    logic       all_visited, illegal_state, bad_transition, stuck;
    logic [3:0] trans_count;
    logic [1:0] mon_state;

    item_t sbq[$];
    int    tests = 0;
    int    fails = 0;

    always #5 clk = ~clk;

    fsm_state_monitor #(
        .SW(2), .NUM_STATES(3), .ALLOWED(9'h04A), .STUCK_LIMIT(4), .CW(4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .clear          (clear),
        .state_valid    (state_valid),
        .state_in       (state_in),
        .visited        (visited),
        .all_visited    (all_visited),
        .illegal_state  (illegal_state),
        .bad_transition (bad_transition),
        .stuck          (stuck),
        .trans_count    (trans_count),
        .mon_state      (mon_state)
    );

    task automatic step(input string nm, input logic r, input logic c, input logic v,
                        input logic [1:0] s, input logic [2:0] evis, input logic eav,
                        input logic eill, input logic ebad, input logic estk,
                        input logic [3:0] etc, input logic [1:0] ems);
        item_t it;
        @(negedge clk);
        rst         = r;
        clear       = c;
        state_valid = v;
        state_in    = s;
        it.name = nm;
        it.e    = {evis, eav, eill, ebad, estk, etc, ems};
        sbq.push_back(it);
    endtask

    always @(posedge clk) begin
        item_t it;
        exp_t  act;
        #1;
        if (sbq.size() > 0) begin
            it  = sbq.pop_front();
            act = {visited, all_visited, illegal_state, bad_transition, stuck, trans_count, mon_state};
            tests++;
            if (act !== it.e) begin
                fails++;
                $display("FAIL %s: got vis=%b av=%b ill=%b bad=%b stk=%b tc=%0d ms=%0d, want vis=%b av=%b ill=%b bad=%b stk=%b tc=%0d ms=%0d",
                         it.name, act.vis, act.av, act.ill, act.bad, act.stk, act.tc, act.ms,
                         it.e.vis, it.e.av, it.e.ill, it.e.bad, it.e.stk, it.e.tc, it.e.ms);
            end
        end
    end

    initial begin
        // 1: reset, then 0,1,0,1 (allowed transitions)
        step("rst0",   1,0,0,2'd0, 3'b000,0,0,0,0,4'd0, 2'd0);
        step("rst1",   1,0,0,2'd0, 3'b000,0,0,0,0,4'd0, 2'd0);
        step("s0",     0,0,1,2'd0, 3'b001,0,0,0,0,4'd0, 2'd1);
        step("s1",     0,0,1,2'd1, 3'b011,0,0,0,0,4'd1, 2'd1);
        step("s0b",    0,0,1,2'd0, 3'b011,0,0,0,0,4'd2, 2'd1);
        step("s1b",    0,0,1,2'd1, 3'b011,0,0,0,0,4'd3, 2'd1);
        // 2: 1->2 disallowed, then 2->0 allowed; bad stays sticky
        step("bad12",  0,0,1,2'd2, 3'b111,1,0,1,0,4'd4, 2'd1);
        step("ok20",   0,0,1,2'd0, 3'b111,1,0,1,0,4'd5, 2'd1);
        // 3: illegal encoding enters FAULT, later samples ignored
        step("ill3",   0,0,1,2'd3, 3'b111,1,1,1,0,4'd5, 2'd2);
        step("flt0",   0,0,1,2'd0, 3'b111,1,1,1,0,4'd5, 2'd2);
        step("flt1",   0,0,1,2'd1, 3'b111,1,1,1,0,4'd5, 2'd2);
        // 4: stuck detection with interleaved gaps
        step("rst4",   1,0,0,2'd0, 3'b000,0,0,0,0,4'd0, 2'd0);
        step("st0",    0,0,1,2'd0, 3'b001,0,0,0,0,4'd0, 2'd1);
        step("rep1",   0,0,1,2'd0, 3'b001,0,0,0,0,4'd0, 2'd1);
        step("gapA",   0,0,0,2'd1, 3'b001,0,0,0,0,4'd0, 2'd1);
        step("rep2",   0,0,1,2'd0, 3'b001,0,0,0,0,4'd0, 2'd1);
        step("gapB",   0,0,0,2'd1, 3'b001,0,0,0,0,4'd0, 2'd1);
        step("rep3",   0,0,1,2'd0, 3'b001,0,0,0,0,4'd0, 2'd1);
        step("gapC",   0,0,0,2'd2, 3'b001,0,0,0,0,4'd0, 2'd1);
        step("rep4",   0,0,1,2'd0, 3'b001,0,0,0,1,4'd0, 2'd1);
        step("rep5",   0,0,1,2'd0, 3'b001,0,0,0,1,4'd0, 2'd1);
        step("unstk",  0,0,1,2'd1, 3'b011,0,0,0,0,4'd1, 2'd1);
        // 5: clear beats a same-cycle sample; then 2->1 disallowed, 1->0 allowed
        step("clrv",   0,1,1,2'd1, 3'b000,0,0,0,0,4'd0, 2'd0);
        step("idle",   0,0,0,2'd1, 3'b000,0,0,0,0,4'd0, 2'd0);
        step("i2",     0,0,1,2'd2, 3'b100,0,0,0,0,4'd0, 2'd1);
        step("bad21",  0,0,1,2'd1, 3'b110,0,0,1,0,4'd1, 2'd1);
        step("ok10",   0,0,1,2'd0, 3'b111,1,0,1,0,4'd2, 2'd1);
        // illegal encoding straight from IDLE
        step("rstI",   1,0,0,2'd0, 3'b000,0,0,0,0,4'd0, 2'd0);
        step("idle3",  0,0,1,2'd3, 3'b000,0,1,0,0,4'd0, 2'd2);
        // 6: saturation of trans_count, then reset mid-stream
        step("rst6",   1,0,0,2'd0, 3'b000,0,0,0,0,4'd0, 2'd0);
        for (int i = 0; i < 20; i++) begin
            step($sformatf("alt%0d", i), 0, 0, 1, 2'(i % 2),
                 (i == 0) ? 3'b001 : 3'b011, 0, 0, 0, 0,
                 4'((i > 15) ? 15 : i), 2'd1);
        end
        step("rstmid", 1,0,1,2'd0, 3'b000,0,0,0,0,4'd0, 2'd0);
        step("post",   0,0,0,2'd0, 3'b000,0,0,0,0,4'd0, 2'd0);

        @(negedge clk);
        rst = 1'b0; state_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending entries, want 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
